// File: rtl/vpu_imul_issue_ctrl.sv
// Issue sequencer for the VPU integer multiply ALU: one operation in flight, start pulse, result hold.
// Optional watchdog enabled by defining VPU_IMUL_CTRL_TIMEOUT_EN.
module vpu_imul_issue_ctrl #(
  parameter int OPCODE_WIDTH    = 32,
  parameter int DELAY_WIDTH     = 4,
  parameter int SRAM_R_PORT_CNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [DELAY_WIDTH-1:0]     req_delay_i,
  input  logic [SRAM_R_PORT_CNT-1:0] req_op_valid_i,
  input  logic [OPCODE_WIDTH-1:0]    req_op0_i,
  input  logic [OPCODE_WIDTH-1:0]    req_op1_i,
  input  logic [OPCODE_WIDTH-1:0]    req_op2_i,
  output logic                       alu_start_o,
  output logic [DELAY_WIDTH-1:0]     alu_delay_o,
  output logic [OPCODE_WIDTH-1:0]    alu_op0_o,
  output logic [OPCODE_WIDTH-1:0]    alu_op1_o,
  output logic [OPCODE_WIDTH-1:0]    alu_op2_o,
  output logic [SRAM_R_PORT_CNT-1:0] alu_op_valid_o,
  input  logic                       alu_done_i,
  input  logic [OPCODE_WIDTH-1:0]    alu_result_i,
  output logic                       dst_valid_o,
  input  logic                       dst_ready_i,
  output logic [OPCODE_WIDTH-1:0]    dst_data_o,
  output logic                       busy_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  state_t state;
  logic   accept;

  // Ready in HOLD depends on the destination taking the current result this cycle.
  assign req_ready_o = (state == IDLE) || ((state == HOLD) && dst_ready_i);
  assign accept      = req_valid_i && req_ready_o;

`ifdef VPU_IMUL_CTRL_TIMEOUT_EN
  localparam int WD_W = DELAY_WIDTH + 2;
  // Cycles since start, last legal value before the watchdog fires.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((2 ** DELAY_WIDTH) + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      alu_start_o    <= 1'b0;
      alu_delay_o    <= '0;
      alu_op0_o      <= '0;
      alu_op1_o      <= '0;
      alu_op2_o      <= '0;
      alu_op_valid_o <= '0;
      dst_valid_o    <= 1'b0;
      dst_data_o     <= '0;
      busy_o         <= 1'b0;
`ifdef VPU_IMUL_CTRL_TIMEOUT_EN
      wd_cnt         <= '0;
      err_o          <= 1'b0;
`endif
    end else begin
      alu_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= START;
            alu_start_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        START: begin
          state <= RUN;
`ifdef VPU_IMUL_CTRL_TIMEOUT_EN
          wd_cnt <= WD_W'(1);
`endif
        end
        RUN: begin
          if (alu_done_i) begin
            dst_data_o  <= alu_result_i;
            dst_valid_o <= 1'b1;
            state       <= HOLD;
          end
`ifdef VPU_IMUL_CTRL_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        HOLD: begin
          if (dst_ready_i) begin
            dst_valid_o <= 1'b0;
            if (accept) begin
              state       <= START;
              alu_start_o <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A zero delay would never let the ALU counter run, so it is forced to one.
      if (accept) begin
        alu_delay_o    <= (req_delay_i == '0) ? DELAY_WIDTH'(1) : req_delay_i;
        alu_op_valid_o <= req_op_valid_i;
        alu_op0_o      <= req_op0_i;
        alu_op1_o      <= req_op1_i;
        alu_op2_o      <= req_op2_i;
      end
    end
  end

endmodule
